load_store_unit: RTL and testbench

- Sits between the CPU datapath (EX/MEM stage) and the word-wide, big-endian data memory.
- The memory has combinational read and a clocked whole-word write.
- This block adds byte, halfword and word loads and stores:
  - loads use lane extraction with sign/zero extension;
  - sub-word stores use a read-modify-write sequence.
- Stalls the CPU with Busy while a transaction is in flight.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/load_store_unit_if.sv | 26 ++
 rtl/lsu_lane_unit.sv | 54 +++++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule used when LSU_ALIGN_CHECK_EN is defined.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACCESS = 2'b01;
    localparam logic [1:0] WRITE  = 2'b10;

    function automatic logic isAligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: isAligned = 1'b1;
            SIZE_HALF: isAligned = (offset[0] == 1'b0);
            SIZE_WORD: isAligned = (offset == 2'b00);
            default:   isAligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response bundle of the load/store unit; the CPU is the
// master, the LSU the slave.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  reqValid;
    logic                  reqWrite;
    logic [1:0]            reqSize;
    logic                  reqUnsigned;
    logic [ADDR_WIDTH-1:0] reqAddress;
    logic [31:0]           reqWriteData;
    logic                  busy;
    logic                  done;
    logic [31:0]           loadData;
    logic                  alignErr;

    modport master (
        output reqValid, reqWrite, reqSize, reqUnsigned, reqAddress, reqWriteData,
        input  busy, done, loadData, alignErr
    );

    modport slave (
        input  reqValid, reqWrite, reqSize, reqUnsigned, reqAddress, reqWriteData,
        output busy, done, loadData, alignErr
    );
endinterface

// File: rtl/lsu_lane_unit.sv
// Big-endian lane logic: extracts and extends a loaded lane, and merges store
// data into an old word for read-modify-write.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] newData_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] extract_o,
    output logic [31:0] merge_o
);
    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    // Byte offset 0 is the most significant byte of the word.
    always_comb begin
        case (offset_i)
            2'd0:    byteLane = word_i[31:24];
            2'd1:    byteLane = word_i[23:16];
            2'd2:    byteLane = word_i[15:8];
            default: byteLane = word_i[7:0];
        endcase
        halfLane = offset_i[1] ? word_i[15:0] : word_i[31:16];
    end

    always_comb begin
        case (size_i)
            SIZE_BYTE: extract_o = {{24{~unsigned_i & byteLane[7]}}, byteLane};
            SIZE_HALF: extract_o = {{16{~unsigned_i & halfLane[15]}}, halfLane};
            default:   extract_o = word_i;
        endcase
    end

    always_comb begin
        merge_o = word_i;
        case (size_i)
            SIZE_BYTE: begin
                case (offset_i)
                    2'd0:    merge_o[31:24] = newData_i[7:0];
                    2'd1:    merge_o[23:16] = newData_i[7:0];
                    2'd2:    merge_o[15:8]  = newData_i[7:0];
                    default: merge_o[7:0]   = newData_i[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (offset_i[1]) merge_o[15:0]  = newData_i[15:0];
                else             merge_o[31:16] = newData_i[15:0];
            end
            default: merge_o = newData_i;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit in front of a word-wide big-endian memory.
// LSU_ALIGN_CHECK_EN: reject misaligned requests with AlignErr; otherwise force-align.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    load_store_unit_if.slave      cpu,
    output logic [ADDR_WIDTH-1:0] memAddress_o,
    output logic [DATA_WIDTH-1:0] memWriteData_o,
    output logic                  memWrite_o,
    output logic                  memRead_o,
    input  logic [DATA_WIDTH-1:0] memReadData_i
);
    logic [1:0]            state_q;
    logic                  write_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           merged_q;
    logic [31:0]           loadData_q;
    logic                  done_q;
    logic                  alignErr_q;

    logic                  misaligned_d;
    logic [1:0]            size_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [31:0]           extracted;
    logic [31:0]           merged;
    logic                  isWordStore;

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        misaligned_d = ~isAligned(cpu.reqSize, cpu.reqAddress[1:0]);
        size_d       = cpu.reqSize;
        addr_d       = cpu.reqAddress;
    end
`else
    // No rejection: the reserved size becomes a word and low address bits are dropped.
    always_comb begin
        misaligned_d = 1'b0;
        size_d       = cpu.reqSize;
        addr_d       = cpu.reqAddress;
        case (cpu.reqSize)
            SIZE_BYTE: addr_d = cpu.reqAddress;
            SIZE_HALF: addr_d = {cpu.reqAddress[ADDR_WIDTH-1:1], 1'b0};
            default: begin
                size_d = SIZE_WORD;
                addr_d = {cpu.reqAddress[ADDR_WIDTH-1:2], 2'b00};
            end
        endcase
    end
`endif

    lsu_lane_unit u_lane (
        .word_i     (memReadData_i),
        .newData_i  (wdata_q),
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .extract_o  (extracted),
        .merge_o    (merged)
    );

    assign isWordStore = write_q && (size_q == SIZE_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            merged_q   <= 32'h0;
            loadData_q <= 32'h0;
            done_q     <= 1'b0;
            alignErr_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            alignErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu.reqValid) begin
                        if (misaligned_d) begin
                            alignErr_q <= 1'b1;
                        end else begin
                            write_q    <= cpu.reqWrite;
                            size_q     <= size_d;
                            unsigned_q <= cpu.reqUnsigned;
                            addr_q     <= addr_d;
                            wdata_q    <= cpu.reqWriteData;
                            state_q    <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!write_q) begin
                        loadData_q <= extracted;
                        done_q     <= 1'b1;
                        state_q    <= IDLE;
                    end else if (isWordStore) begin
                        done_q     <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        merged_q   <= merged;
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory strobes come straight from the state so a reset cancels them at once.
    always_comb begin
        memAddress_o   = '0;
        memWriteData_o = '0;
        memWrite_o     = 1'b0;
        memRead_o      = 1'b0;
        case (state_q)
            ACCESS: begin
                memAddress_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                if (isWordStore) begin
                    memWrite_o     = 1'b1;
                    memWriteData_o = wdata_q;
                end else begin
                    memRead_o = 1'b1;
                end
            end
            WRITE: begin
                memAddress_o   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                memWrite_o     = 1'b1;
                memWriteData_o = merged_q;
            end
            default: ;
        endcase
    end

    assign cpu.busy     = (state_q != IDLE);
    assign cpu.done     = done_q;
    assign cpu.loadData = loadData_q;
    assign cpu.alignErr = alignErr_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a behavioural word memory.
// Follows LSU_ALIGN_CHECK_EN the same way the design does.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] memReadData;

    logic [31:0] mem [16];
    logic [31:0] refMem [16];
    logic        loadEn = 1'b0;
    logic [3:0]  loadIdx = 4'd0;
    logic [31:0] loadVal = 32'h0;

    typedef struct {
        logic        isLoad;
        logic [31:0] data;
        logic [31:0] addr;
    } sbItem_t;
    sbItem_t sb [$];

    int          testsRun = 0;
    int          failCount = 0;
    logic [31:0] lastLoad = 32'h0;

    load_store_unit_if #(.ADDR_WIDTH(32)) cpuIf ();

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu            (cpuIf),
        .memAddress_o   (memAddress),
        .memWriteData_o (memWriteData),
        .memWrite_o     (memWrite),
        .memRead_o      (memRead),
        .memReadData_i  (memReadData)
    );

    always #5 clk = ~clk;

    assign memReadData = mem[memAddress[5:2]];

    always @(posedge clk) begin
        if (loadEn) mem[loadIdx] <= loadVal;
        else if (memWrite) mem[memAddress[5:2]] <= memWriteData;
    end

    function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [31:0] addr,
                                            input logic [1:0] size, input logic uns);
        logic [31:0] v;
        int sh;
        if (size == 2'b00) begin
            sh = 24 - 8 * int'(addr[1:0]);
            v = (word >> sh) & 32'h000000FF;
            if (!uns && v[7]) v = v | 32'hFFFFFF00;
        end else if (size == 2'b01) begin
            sh = addr[1] ? 0 : 16;
            v = (word >> sh) & 32'h0000FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] refMerge(input logic [31:0] oldWord, input logic [31:0] newData,
                                             input logic [31:0] addr, input logic [1:0] size);
        logic [31:0] mask;
        int sh;
        if (size == 2'b00) begin
            sh = 24 - 8 * int'(addr[1:0]);
            mask = 32'h000000FF << sh;
        end else if (size == 2'b01) begin
            sh = addr[1] ? 0 : 16;
            mask = 32'h0000FFFF << sh;
        end else begin
            return newData;
        end
        return (oldWord & ~mask) | ((newData << sh) & mask);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic w, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        cpuIf.reqValid     = valid;
        cpuIf.reqWrite     = w;
        cpuIf.reqSize      = size;
        cpuIf.reqUnsigned  = uns;
        cpuIf.reqAddress   = addr;
        cpuIf.reqWriteData = wdata;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        loadIdx = idx;
        loadVal = val;
        loadEn  = 1'b1;
        refMem[idx] = val;
        @(posedge clk);
        #1 loadEn = 1'b0;
    endtask

    // Caller sits 1ns after an edge; returns at the Done cycle without advancing.
    task automatic runTxn(input string tag, input logic w, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int expLat);
        sbItem_t     item;
        sbItem_t     got;
        logic [31:0] effAddr;
        logic [1:0]  effSize;
        int          cycles;
        int          writes;
        int          both;
        logic        gotDone;

        effAddr = addr;
        effSize = size;
`ifndef LSU_ALIGN_CHECK_EN
        if (size == 2'b11) effSize = 2'b10;
        if (effSize == 2'b01) effAddr = {addr[31:1], 1'b0};
        if (effSize == 2'b10) effAddr = {addr[31:2], 2'b00};
`endif
        item.isLoad = !w;
        item.addr   = {effAddr[31:2], 2'b00};
        if (!w) begin
            item.data = refLoad(refMem[effAddr[5:2]], effAddr, effSize, uns);
        end else begin
            item.data = refMerge(refMem[effAddr[5:2]], wdata, effAddr, effSize);
            refMem[effAddr[5:2]] = item.data;
        end
        sb.push_back(item);

        applyStimulus(1'b1, w, size, uns, addr, wdata);
        @(posedge clk);
        #1 applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        checkOutput({tag, ".busy"}, {31'h0, cpuIf.busy}, 32'h1);

        cycles = 1; writes = 0; both = 0; gotDone = 1'b0;
        while (!gotDone && cycles < 8) begin
            if (memWrite) begin
                writes++;
                checkOutput({tag, ".wdata"}, memWriteData, sb[0].data);
                checkOutput({tag, ".waddr"}, memAddress, sb[0].addr);
            end
            if (memRead && memWrite) both++;
            @(posedge clk);
            #1 cycles++;
            if (cpuIf.done) gotDone = 1'b1;
        end
        checkOutput({tag, ".doneSeen"}, {31'h0, gotDone}, 32'h1);
        checkOutput({tag, ".latency"}, cycles, expLat);
        checkOutput({tag, ".rdwr"}, both, 0);
        checkOutput({tag, ".busyAtDone"}, {31'h0, cpuIf.busy}, 32'h0);
        got = sb.pop_front();
        if (got.isLoad) begin
            checkOutput({tag, ".loadData"}, cpuIf.loadData, got.data);
            checkOutput({tag, ".noWrite"}, writes, 0);
            lastLoad = got.data;
        end else begin
            checkOutput({tag, ".writePulses"}, writes, 1);
            checkOutput({tag, ".loadHeld"}, cpuIf.loadData, lastLoad);
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) refMem[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.busy", {31'h0, cpuIf.busy}, 32'h0);
        checkOutput("rst.done", {31'h0, cpuIf.done}, 32'h0);
        checkOutput("rst.loadData", cpuIf.loadData, 32'h0);
        checkOutput("rst.alignErr", {31'h0, cpuIf.alignErr}, 32'h0);
        checkOutput("rst.memWrite", {31'h0, memWrite}, 32'h0);
        checkOutput("rst.memRead", {31'h0, memRead}, 32'h0);
        checkOutput("rst.memAddress", memAddress, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) preload(i[3:0], 32'h0);
        preload(4'd2, 32'h11223344);
        preload(4'd3, 32'h55667788);

        $display("[TB] reset in the middle of a byte store");
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 32'd13, 32'h000000AB);
        @(posedge clk);
        #1 applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        checkOutput("midrst.busyBefore", {31'h0, cpuIf.busy}, 32'h1);
        checkOutput("midrst.readBefore", {31'h0, memRead}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("midrst.busy", {31'h0, cpuIf.busy}, 32'h0);
        checkOutput("midrst.memRead", {31'h0, memRead}, 32'h0);
        checkOutput("midrst.memAddress", memAddress, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("midrst.memWrite", {31'h0, memWrite}, 32'h0);
            @(posedge clk);
            #1;
        end
        checkOutput("midrst.done", {31'h0, cpuIf.done}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1 checkOutput("midrst.memUnchanged", mem[3], 32'h55667788);

        $display("[TB] loads from 0x11223344 at address 8");
        runTxn("lb9", 1'b0, 2'b00, 1'b0, 32'd9, 32'h0, 2);
        runTxn("lhu10", 1'b0, 2'b01, 1'b1, 32'd10, 32'h0, 2);
        runTxn("lb11", 1'b0, 2'b00, 1'b0, 32'd11, 32'h0, 2);
        runTxn("lw8", 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 2);
        @(posedge clk);
        #1 preload(4'd2, 32'h80223344);
        runTxn("lb8s", 1'b0, 2'b00, 1'b0, 32'd8, 32'h0, 2);
        runTxn("lbu8", 1'b0, 2'b00, 1'b1, 32'd8, 32'h0, 2);
        runTxn("lh8s", 1'b0, 2'b01, 1'b0, 32'd8, 32'h0, 2);

        $display("[TB] stores");
        runTxn("sb13", 1'b1, 2'b00, 1'b0, 32'd13, 32'h123456AB, 3);
        checkOutput("sb13.result", sb.size(), 0);
        @(posedge clk);
        #1 checkOutput("sb13.mem", mem[3], 32'h55AB7788);
        runTxn("sw4", 1'b1, 2'b10, 1'b0, 32'd4, 32'hDEADBEEF, 2);
        runTxn("lw4b2b", 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 2);
        runTxn("sh6", 1'b1, 2'b01, 1'b0, 32'd6, 32'hFFFF1234, 3);
        runTxn("lw4", 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 2);
        runTxn("sb4", 1'b1, 2'b00, 1'b0, 32'd4, 32'h00000077, 3);
        runTxn("lbu4", 1'b0, 2'b00, 1'b1, 32'd4, 32'h0, 2);

        $display("[TB] misaligned requests");
        @(posedge clk);
        #1;
`ifdef LSU_ALIGN_CHECK_EN
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'd5, 32'h0);
        @(posedge clk);
        #1 applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        checkOutput("lh5.alignErr", {31'h0, cpuIf.alignErr}, 32'h1);
        checkOutput("lh5.busy", {31'h0, cpuIf.busy}, 32'h0);
        checkOutput("lh5.memRead", {31'h0, memRead}, 32'h0);
        checkOutput("lh5.done", {31'h0, cpuIf.done}, 32'h0);
        @(posedge clk);
        #1 checkOutput("lh5.pulse", {31'h0, cpuIf.alignErr}, 32'h0);
        applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 32'd4, 32'h0);
        @(posedge clk);
        #1 applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        checkOutput("rsvd.alignErr", {31'h0, cpuIf.alignErr}, 32'h1);
        checkOutput("rsvd.memWrite", {31'h0, memWrite}, 32'h0);
        checkOutput("rsvd.busy", {31'h0, cpuIf.busy}, 32'h0);
`else
        runTxn("lh5", 1'b0, 2'b01, 1'b0, 32'd5, 32'h0, 2);
        runTxn("lw6", 1'b0, 2'b10, 1'b0, 32'd6, 32'h0, 2);
        runTxn("rsvd4", 1'b0, 2'b11, 1'b0, 32'd4, 32'h0, 2);
        checkOutput("lh5.alignErr", {31'h0, cpuIf.alignErr}, 32'h0);
`endif

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
